// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: accepts interrupts at Q4 instruction boundaries,
// forces NOP cycles and vectors the PC. Optional INT-pin edge detector under PIC_INT_PIN_EN.
module interrupt_sequencer #(
  parameter int                  PC_WIDTH     = 13,
  parameter logic [PC_WIDTH-1:0] VECTOR_ADDR  = 13'h004,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          q_phase,
  input  logic                instr_last,
  input  logic                is_retfie,
  input  logic [7:0]          intcon_in,
  input  logic [7:0]          pie1_in,
  input  logic [7:0]          pir1_in,
`ifdef PIC_INT_PIN_EN
  input  logic                int_pin,
  input  logic                intedg,
  output logic                intf_set,
`endif
  output logic                int_take,
  output logic                stack_push,
  output logic                gie_clr,
  output logic                gie_set,
  output logic                int_flush,
  output logic                pc_vec_en,
  output logic [PC_WIDTH-1:0] pc_vec_addr,
  output logic                busy
);

  localparam int CW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] flush_cnt;
  logic          boundary;
  logic          pending;
  logic          q4;

  wire gie  = intcon_in[7];
  wire peie = intcon_in[6];
  wire t0ie = intcon_in[5];
  wire inte = intcon_in[4];
  wire rbie = intcon_in[3];
  wire t0if = intcon_in[2];
  wire intf = intcon_in[1];
  wire rbif = intcon_in[0];

  assign q4       = (q_phase == 2'd3);
  assign boundary = q4 && instr_last;
  assign pending  = gie && ((t0ie && t0if) || (inte && intf) || (rbie && rbif) ||
                            (peie && (|(pie1_in & pir1_in))));

  // Entry/exit pulses are combinational so they land in the boundary clock itself;
  // gating with rst keeps every output low for the whole reset interval.
  assign int_take   = !rst && (state == IDLE) && boundary && pending && !is_retfie;
  assign stack_push = int_take;
  assign gie_clr    = int_take;
  assign gie_set    = !rst && (state == IDLE) && boundary && is_retfie;

  assign int_flush   = (state == FLUSH);
  assign busy        = (state != IDLE);
  assign pc_vec_en   = (state == FLUSH) && q4 && (flush_cnt == CNT_LOAD);
  assign pc_vec_addr = VECTOR_ADDR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (int_take) begin
            state     <= FLUSH;
            flush_cnt <= CNT_LOAD;
          end
        end
        FLUSH: begin
          if (q4) begin
            if (flush_cnt == '0) state <= IDLE;
            else                 flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIC_INT_PIN_EN
  // Two-flop synchroniser, then a delayed copy for edge detection; the edge pulse
  // is registered, giving three clocks from pin to intf_set.
  logic pin_s1, pin_s2, pin_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_s1   <= 1'b0;
      pin_s2   <= 1'b0;
      pin_s3   <= 1'b0;
      intf_set <= 1'b0;
    end else begin
      pin_s1   <= int_pin;
      pin_s2   <= pin_s1;
      pin_s3   <= pin_s2;
      intf_set <= intedg ? (pin_s2 && !pin_s3) : (!pin_s2 && pin_s3);
    end
  end
`endif

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed testbench for interrupt_sequencer; INT-pin checks compile only with PIC_INT_PIN_EN.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  q_phase = 2'd0;
  logic        instr_last = 1'b1;
  logic        is_retfie = 1'b0;
  logic [7:0]  intcon_in = 8'h00;
  logic [7:0]  pie1_in = 8'h00;
  logic [7:0]  pir1_in = 8'h00;
  logic        int_take, stack_push, gie_clr, gie_set, int_flush, pc_vec_en, busy;
  logic [12:0] pc_vec_addr;
`ifdef PIC_INT_PIN_EN
  logic        int_pin = 1'b0;
  logic        intedg = 1'b1;
  logic        intf_set;
`endif

  int checks = 0;
  int errors = 0;

  logic o_take, o_push, o_clr, o_set, o_flush, o_vec, o_busy;
  logic [12:0] o_addr;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .q_phase(q_phase), .instr_last(instr_last),
    .is_retfie(is_retfie), .intcon_in(intcon_in), .pie1_in(pie1_in), .pir1_in(pir1_in),
`ifdef PIC_INT_PIN_EN
    .int_pin(int_pin), .intedg(intedg), .intf_set(intf_set),
`endif
    .int_take(int_take), .stack_push(stack_push), .gie_clr(gie_clr), .gie_set(gie_set),
    .int_flush(int_flush), .pc_vec_en(pc_vec_en), .pc_vec_addr(pc_vec_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1: drive inputs, sample outputs mid-cycle, advance one clock.
  task automatic tick(input logic [1:0] q, input logic last, input logic retfie);
    q_phase    = q;
    instr_last = last;
    is_retfie  = retfie;
    #2;
    o_take = int_take;  o_push = stack_push; o_clr = gie_clr; o_set = gie_set;
    o_flush = int_flush; o_vec = pc_vec_en; o_busy = busy; o_addr = pc_vec_addr;
    @(posedge clk);
    #1;
  endtask

  // Runs the instruction cycle ending in an accepted boundary, checking the entry pulses.
  task automatic enter(input string tag);
    for (int q = 0; q < 3; q++) begin
      tick(2'(q), 1'b1, 1'b0);
      if (o_take) check({tag, "_early_take"}, o_take, 1'b0);
    end
    tick(2'd3, 1'b1, 1'b0);
    check({tag, "_take"}, {o_take, o_push, o_clr, o_set, o_busy}, 5'b11100);
  endtask

  // Eight forced-NOP clocks; pc_vec_en must fire only on the 4th with the vector address.
  task automatic run_flush(input string tag);
    int nflush = 0, nvec = 0, vec_at = -1, ntake = 0;
    for (int i = 0; i < 8; i++) begin
      tick(2'(i % 4), 1'b1, 1'b0);
      nflush += int'(o_flush && o_busy);
      ntake  += int'(o_take || o_set);
      if (o_vec) begin
        nvec++;
        vec_at = i;
        check({tag, "_vec_addr"}, 32'(o_addr), 32'h004);
      end
    end
    check({tag, "_flush_clks"}, nflush, 8);
    check({tag, "_vec_count"}, nvec, 1);
    check({tag, "_vec_pos"}, vec_at, 3);
    check({tag, "_no_take_in_flush"}, ntake, 0);
    tick(2'd0, 1'b1, 1'b0);
    check({tag, "_back_idle"}, {o_flush, o_busy}, 2'b00);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_outputs", {int_take, stack_push, gie_clr, gie_set, int_flush, pc_vec_en, busy}, 7'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Timer interrupt entry
    intcon_in = 8'hA4;
    enter("t0");
    intcon_in = 8'h24;
    run_flush("t0");

    // Peripheral interrupt gated by GIE and PEIE
    pie1_in = 8'h01; pir1_in = 8'h01;
    intcon_in = 8'h40;
    for (int q = 0; q < 4; q++) tick(2'(q), 1'b1, 1'b0);
    check("periph_no_gie", o_take, 1'b0);
    intcon_in = 8'h80;
    for (int q = 0; q < 4; q++) tick(2'(q), 1'b1, 1'b0);
    check("periph_no_peie", o_take, 1'b0);
    intcon_in = 8'hC0;
    enter("periph");
    intcon_in = 8'h40;
    run_flush("periph");
    pie1_in = 8'h00; pir1_in = 8'h00;

    // Two-cycle instruction: first-half Q4 must not accept
    intcon_in = 8'hA4;
    for (int q = 0; q < 4; q++) tick(2'(q), 1'b0, 1'b0);
    check("goto_first_half", {o_take, o_busy}, 2'b00);
    enter("goto");
    intcon_in = 8'h24;
    run_flush("goto");

    // RETFIE with flag pending: gie_set only, entry at the following boundary
    for (int q = 0; q < 3; q++) tick(2'(q), 1'b1, 1'b1);
    tick(2'd3, 1'b1, 1'b1);
    check("retfie_set", {o_set, o_take, o_push, o_clr}, 4'b1000);
    intcon_in = 8'hA4;
    enter("after_retfie");
    intcon_in = 8'h24;

    // Asynchronous reset in the middle of FLUSH
    tick(2'd0, 1'b1, 1'b0);
    tick(2'd1, 1'b1, 1'b0);
    check("pre_rst_flush", {o_flush, o_busy}, 2'b11);
    q_phase = 2'd3;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst", {int_flush, busy, pc_vec_en, int_take}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2'd3, 1'b1, 1'b0);
    check("post_rst_idle", {o_flush, o_busy, o_vec}, 3'b000);

`ifdef PIC_INT_PIN_EN
    // Rising edge with intedg=1: pulse exactly 3 clocks after the pin change
    begin
      int npulse, pos;
      intedg = 1'b1;
      int_pin = 1'b1;
      npulse = 0; pos = -1;
      for (int i = 1; i <= 6; i++) begin
        @(posedge clk); #1;
        if (intf_set) begin npulse++; pos = i; end
      end
      check("pin_rise_count", npulse, 1);
      check("pin_rise_latency", pos, 3);
      intedg = 1'b0;
      int_pin = 1'b0;
      npulse = 0; pos = -1;
      for (int i = 1; i <= 6; i++) begin
        @(posedge clk); #1;
        if (intf_set) begin npulse++; pos = i; end
      end
      check("pin_fall_count", npulse, 1);
      check("pin_fall_latency", pos, 3);
      int_pin = 1'b1;
      npulse = 0;
      for (int i = 1; i <= 6; i++) begin
        @(posedge clk); #1;
        if (intf_set) npulse++;
      end
      check("pin_rise_ignored", npulse, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
